// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 widths, fetch FSM encoding and instruction constants
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush kills the entry, enable captures a new one
module if_id_reg import rv_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr
);
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4_q, pc_plus4_d, instr_q, instr_d;
  // next entry: flush only clears valid, payload fields are held
  always_comb begin
    valid_d    = flush ? 1'b0 : en ? 1'b1 : valid_q;
    pc_d       = (en && !flush) ? pc_i : pc_q;
    pc_plus4_d = (en && !flush) ? pc_plus4_i : pc_plus4_q;
    instr_d    = (en && !flush) ? instr_i : instr_q;
  end
  // entry storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end
  assign valid    = valid_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign instr    = instr_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing with boot/run/halt control feeding the IF/ID register
module fetch_stage import rv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] HALT_WORD    = HALT_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            halted,
  output logic            misalign_err
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic            halted_q, halted_d, misalign_q, misalign_d, cap_en, flush;
  assign pc_plus4 = pc_q + 32'd4;
  // next-state: redirect beats stall, stall beats halt detection and advance
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    cap_en     = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = HALT;
      end else begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end else if (!stall && state_q == RUN) begin
      if (imem_rdata == HALT_WORD) begin
        flush   = 1'b1;
        state_d = HALT;
      end else begin
        cap_en = 1'b1;
        pc_d   = pc_plus4;
      end
    end
    halted_d = state_d == HALT;
  end
  // control state with registered halted flag and sticky misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end
  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (cap_en),
    .flush      (flush),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_i    (imem_rdata),
    .valid      (ifid_valid),
    .pc         (ifid_pc),
    .pc_plus4   (ifid_pc_plus4),
    .instr      (ifid_instr)
  );
  assign imem_addr    = pc_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC loaded on reset.
REQ-003 Parameter HALT_WORD, default 32'h0000_0000, is the fetched word that halts fetch.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_addr  output  32  byte address to instruction memory; equals pc_q, combinational.
REQ-007 imem_rdata  input  32  little-endian word returned combinationally for imem_addr in the same cycle.
REQ-008 stall  input  1  hold PC and IF/ID register, from hazard unit.
REQ-009 redirect  input  1  taken branch/jump; load redirect_pc and flush.
REQ-010 redirect_pc  input  32  redirect target byte address.
REQ-011 ifid_valid  output  1  IF/ID entry holds a live instruction.
REQ-012 ifid_pc  output  32  PC of ifid_instr.
REQ-013 ifid_pc_plus4  output  32  ifid_pc + 4, modulo 2^32.
REQ-014 ifid_instr  output  32  captured instruction word.
REQ-015 halted  output  1  high while in HALT.
REQ-016 misalign_err  output  1  sticky; redirect_pc[1:0] != 0 was accepted.

Function
REQ-017 The FSM SHALL have states BOOT, RUN, HALT; reset enters BOOT.
REQ-018 BOOT SHALL last exactly one cycle, capture nothing, hold pc_q, then go to RUN.
REQ-019 In RUN with no stall/redirect, each edge SHALL load IF/ID with {valid=1, pc_q, pc_q+4, imem_rdata} and set pc_q <= pc_q+4.
REQ-020 Fetch latency SHALL be one cycle: a word at pc_q appears on ifid_* after the next rising edge.
REQ-021 Priority SHALL be redirect > stall > halt detection > normal advance.
REQ-022 Redirect (any state) SHALL set pc_q <= redirect_pc and ifid_valid <= 0, go to RUN, and ignore stall that cycle.
REQ-023 Redirect with redirect_pc[1:0] != 0 SHALL instead set misalign_err <= 1, ifid_valid <= 0, hold pc_q, go to HALT.
REQ-024 Stall without redirect SHALL hold pc_q, all ifid_* outputs and FSM state unchanged.
REQ-025 In RUN, imem_rdata == HALT_WORD without stall/redirect SHALL set ifid_valid <= 0, hold pc_q, go to HALT.
REQ-026 HALT SHALL hold pc_q, keep ifid_valid at 0, drive halted=1; only redirect or reset exits.
REQ-027 PC arithmetic SHALL be 32-bit unsigned and wrap 32'hFFFF_FFFC -> 32'h0000_0000 without flagging.
REQ-028 misalign_err SHALL stay set until reset.

Reset
REQ-029 On rst_n low, asynchronously: pc_q=RESET_VECTOR, state=BOOT, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=0, halted=0, misalign_err=0.
REQ-030 Reset mid-stall, mid-redirect or in HALT SHALL discard all in-flight state; first fetch address after release is RESET_VECTOR.

Structure
REQ-031 FSM state encoding, XLEN=32, and the NOP/HALT_WORD constants SHALL live in shared package rv_pkg.
REQ-032 The IF/ID register SHALL be one sub-module, if_id_reg (valid, pc, pc_plus4, instr; enable and flush inputs).
REQ-033 The block SHALL connect directly to the existing combinational instruction memory with no extra buffering.

Verification
REQ-034 Reset release, imem word0=32'h004081B3, word4=32'h401181B3 -> cycle1 BOOT no capture; cycle2 ifid={1,0x0,0x4,0x004081B3}; cycle3 ifid_pc=0x4.
REQ-035 stall high 3 cycles at pc_q=0x8 -> imem_addr stays 0x8, ifid_* unchanged, advance resumes on deassert.
REQ-036 redirect=1, redirect_pc=0x10 with stall=1 -> next cycle pc_q=0x10, ifid_valid=0; following cycle ifid_pc=0x10.
REQ-037 imem_rdata=0x00000000 at pc_q=0x14 -> ifid_valid=0, halted=1, imem_addr frozen at 0x14; redirect to 0x0 -> RUN, halted=0.
REQ-038 redirect_pc=0x12 -> misalign_err=1, halted=1, pc_q unchanged; persists after further redirects until rst_n low.
REQ-039 RESET_VECTOR=32'hFFFF_FFFC -> second capture ifid_pc=0x0, ifid_pc_plus4=0x4; rst_n pulsed low in HALT -> all outputs return to REQ-029 values immediately.
